// File: rtl/axis_lfsr_scrambler.sv
// axis_lfsr_scrambler: AXI-Stream additive LFSR scrambler with frame-start reseed; optional SCRAMBLER_SEED_LOAD_EN macro adds a per-frame seed input
module axis_lfsr_scrambler #(
    parameter int                  WIDTH     = 32,
    parameter int                  LFSR_LEN  = 7,
    parameter logic [LFSR_LEN-1:0] POLY      = 7'b1001000,
    parameter logic [LFSR_LEN-1:0] SEED      = '1,
    parameter int                  TAIL_BITS = 7
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic [WIDTH-1:0]    s_axis_tdata,
    input  logic [3:0]          s_axis_tuser,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    input  logic                s_axis_tlast,
`ifdef SCRAMBLER_SEED_LOAD_EN
    input  logic [LFSR_LEN-1:0] s_axis_tseed,
`endif
    output logic [WIDTH-1:0]    m_axis_tdata,
    output logic [3:0]          m_axis_tuser,
    output logic                m_axis_tlast,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    input  logic                bypass,
    output logic                in_frame
);
    typedef enum logic {IDLE, FRAME} state_t;
    localparam logic [WIDTH-1:0] KEEP = {WIDTH{1'b1}} >> TAIL_BITS;
    state_t              state_q, state_d;
    logic [LFSR_LEN-1:0] lfsr_q, lfsr_d, start_st, cur_st;
    logic [WIDTH-1:0]    key, tdata_q, tdata_d;
    logic [3:0]          tuser_q, tuser_d;
    logic                tlast_q, tlast_d, tvalid_q, tvalid_d, accept;

    // Unrolls the recurrence R(m) = XOR POLY[k] R(m-k-1) for WIDTH steps; bit 0 is earliest.
    function automatic logic [WIDTH-1:0] keystream(input logic [LFSR_LEN-1:0] st);
        logic [WIDTH+LFSR_LEN-1:0] s;
        s = '0;
        s[LFSR_LEN-1:0] = st;
        for (int i = 0; i < WIDTH; i++)
            for (int k = 0; k < LFSR_LEN; k++)
                if (POLY[k]) s[LFSR_LEN+i] = s[LFSR_LEN+i] ^ s[LFSR_LEN+i-k-1];
        return s[WIDTH+LFSR_LEN-1:LFSR_LEN];
    endfunction

`ifdef SCRAMBLER_SEED_LOAD_EN
    assign start_st = (s_axis_tseed == '0) ? SEED : s_axis_tseed;
`else
    assign start_st = SEED;
`endif
    assign s_axis_tready = !areset && (!tvalid_q || m_axis_tready);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign cur_st        = (state_q == IDLE) ? start_st : lfsr_q;
    assign key           = keystream(cur_st);
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tvalid = tvalid_q;
    assign in_frame      = (state_q == FRAME);

    // Next state: frame tracking, key continuation and the output register load/drain.
    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        tuser_d  = tuser_q;
        tlast_d  = tlast_q;
        if (accept) begin
            state_d  = s_axis_tlast ? IDLE : FRAME;
            lfsr_d   = key[WIDTH-1 -: LFSR_LEN];
            tvalid_d = 1'b1;
            tdata_d  = (bypass ? s_axis_tdata : s_axis_tdata ^ key) & (s_axis_tlast ? KEEP : {WIDTH{1'b1}});
            tuser_d  = s_axis_tuser;
            tlast_d  = s_axis_tlast;
        end else if (m_axis_tready) begin
            tvalid_d = 1'b0;
        end
    end

    // State registers; reset drops any pending beat and returns to frame start.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q  <= IDLE;
            lfsr_q   <= SEED;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tuser_q  <= '0;
            tlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tuser_q  <= tuser_d;
            tlast_q  <= tlast_d;
        end
    end
endmodule
